// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants and types for the fetch stage: address/instruction widths,
// reset PC, HALT opcode and the {pc,instr} entry carried from fetch to decode.
package fetch_unit_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;

    localparam logic [PC_W-1:0] RESET_PC = 12'h000;
    localparam logic [PC_W-1:0] PC_ONE   = 12'h001;
    localparam logic [OP_W-1:0] HALT_OP  = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [OP_W-1:0] opcode(input logic [INSTR_W-1:0] instr);
        return instr[15:12];
    endfunction

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return opcode(instr) == HALT_OP;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory address/data, branch redirect and the
// valid/ready fetch-to-decode channel. master = fetch unit, slave = CPU/memory side.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [PC_W-1:0]    o_imem_pc;
    logic [INSTR_W-1:0] i_imem_instr;
    logic               i_redirect;
    logic [PC_W-1:0]    i_redirect_pc;
    logic               o_fd_valid;
    logic               i_fd_ready;
    logic [PC_W-1:0]    o_fd_pc;
    logic [INSTR_W-1:0] o_fd_instr;
    logic               o_halted;

    modport master (
        output o_imem_pc,
        input  i_imem_instr,
        input  i_redirect,
        input  i_redirect_pc,
        output o_fd_valid,
        input  i_fd_ready,
        output o_fd_pc,
        output o_fd_instr,
        output o_halted
    );

    modport slave (
        input  o_imem_pc,
        output i_imem_instr,
        output i_redirect,
        output i_redirect_pc,
        input  o_fd_valid,
        output i_fd_ready,
        input  o_fd_pc,
        input  o_fd_instr,
        input  o_halted
    );

endinterface

// File: rtl/fetch_q2_chk.sv
// Protocol checker for the 2-entry fetch queue: a push into a full queue is only
// legal when the head leaves in the same cycle or the queue is being flushed.
module fetch_q2_chk (
    input logic i_clk,
    input logic i_reset,
    input logic i_push,
    input logic i_pop,
    input logic i_flush,
    input logic i_full
);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(i_push && i_full && !i_pop && !i_flush));

endmodule

// File: rtl/fetch_unit_q2.sv
// 2-entry shifting FIFO of {pc,instr}; the head always sits in the same register so
// the decode-facing outputs come straight from flops.
module fetch_q2
    import fetch_unit_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop_s;

    // Next-state for head/tail slots and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_s   = i_pop & (count_q != 2'd0);
        if (i_flush) begin
            count_d = 2'd0;
        end else begin
            case ({i_push, pop_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = i_data;
                    end else begin
                        tail_d = i_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = i_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = i_data;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Queue storage registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign o_head  = head_q;
    assign o_count = count_q;
    assign o_full  = (count_q == 2'd2);
    assign o_empty = (count_q == 2'd0);

    fetch_q2_chk u_chk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_push),
        .i_pop   (pop_s),
        .i_flush (i_flush),
        .i_full  (o_full)
    );

endmodule

// File: rtl/fetch_unit.sv
// PC generator and fetch buffer: issues addresses to a 1-cycle sync-read instruction
// memory, queues returning {pc,instr} for decode, handles redirect flush and HALT.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset,
    fetch_unit_if.master bus
);

    logic [PC_W-1:0] r_pc_q, r_pc_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    fetch_state_e    state_q, state_d;

    fetch_entry_t    q_head_s;
    fetch_entry_t    push_data_s;
    logic [1:0]      q_count_s;
    logic            q_full_s;
    logic            q_empty_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic            halt_push_s;
    logic [2:0]      occ_s;
    logic            issue_s;

    // Handshake, credit and capture decisions for this cycle
    always_comb begin
        pop_s             = !q_empty_s & bus.i_fd_ready;
        drop_s            = bus.i_redirect | (state_q == ST_HALT);
        push_s            = inflight_q & !drop_s;
        push_data_s.pc    = inflight_pc_q;
        push_data_s.instr = bus.i_imem_instr;
        halt_push_s       = push_s & is_halt(bus.i_imem_instr);
        // pop implies count >= 1, so the subtraction cannot wrap
        occ_s   = {1'b0, q_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s = (state_q == ST_RUN) & !bus.i_redirect & !halt_push_s & (occ_s < 3'd2);
    end

    // PC, in-flight tracking and RUN/HALT next state
    always_comb begin
        r_pc_d        = r_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue_s;
        state_d       = state_q;
        if (bus.i_redirect) begin
            r_pc_d = bus.i_redirect_pc;
        end else if (issue_s) begin
            r_pc_d        = r_pc_q + PC_ONE;
            inflight_pc_d = r_pc_q;
        end else begin
            r_pc_d = r_pc_q;
        end
        case (state_q)
            ST_RUN: begin
                if (!bus.i_redirect && halt_push_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.i_redirect) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Fetch control registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc_q        <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            state_q       <= ST_RUN;
        end else begin
            r_pc_q        <= r_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            state_q       <= state_d;
        end
    end

    fetch_q2 u_q (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push_s),
        .i_pop   (pop_s),
        .i_flush (bus.i_redirect),
        .i_data  (push_data_s),
        .o_head  (q_head_s),
        .o_count (q_count_s),
        .o_full  (q_full_s),
        .o_empty (q_empty_s)
    );

    assign bus.o_imem_pc  = r_pc_q;
    assign bus.o_fd_valid = !q_empty_s;
    assign bus.o_fd_pc    = q_head_s.pc;
    assign bus.o_fd_instr = q_head_s.instr;
    assign bus.o_halted   = (state_q == ST_HALT);

endmodule
